// File: rtl/buzzer_pkg.sv
// Shared definitions for the buzzer path: melody ROM word layout, sequencer
// state encoding and the note-index constants understood by buzzer_ctrl.
package buzzer_pkg;

    localparam int ROM_W     = 8;
    localparam int REST_BIT  = 7;
    localparam int PITCH_LSB = 3;
    localparam int PITCH_W   = 4;
    localparam int DUR_LSB   = 0;
    localparam int DUR_W     = 3;

    localparam logic [ROM_W-1:0] END_CODE = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_PLAY  = 2'd2,
        ST_GAP   = 2'd3
    } seq_state_e;

    typedef logic [PITCH_W-1:0] note_t;

    localparam note_t NOTE_C4 = 4'd0,  NOTE_CS4 = 4'd1,  NOTE_D4 = 4'd2,  NOTE_DS4 = 4'd3;
    localparam note_t NOTE_E4 = 4'd4,  NOTE_F4  = 4'd5,  NOTE_FS4 = 4'd6, NOTE_G4  = 4'd7;
    localparam note_t NOTE_GS4 = 4'd8, NOTE_A4  = 4'd9,  NOTE_AS4 = 4'd10, NOTE_B4 = 4'd11;
    localparam note_t NOTE_C5 = 4'd12, NOTE_CS5 = 4'd13, NOTE_D5 = 4'd14, NOTE_DS5 = 4'd15;

    function automatic logic is_end(input logic [ROM_W-1:0] w);
        return w == END_CODE;
    endfunction

endpackage

// File: rtl/melody_sequencer_if.sv
// Control/status bundle between the button logic, the sequencer and buzzer_ctrl.
interface melody_sequencer_if
    import buzzer_pkg::*;
#(
    parameter int IDX_W = 5
);
    logic             start;
    logic             stop;
    note_t            data;
    logic             sound_on;
    logic             busy;
    logic [IDX_W-1:0] note_idx;

    modport master (input start, stop, output data, sound_on, busy, note_idx);
    modport slave  (output start, stop, input data, sound_on, busy, note_idx);
endinterface

// File: rtl/melody_rom.sv
// LEN x 8 melody ROM with a registered read port; contents come from INIT
// (entry 0 in the least significant byte).
module melody_rom
    import buzzer_pkg::*;
#(
    parameter int                         LEN   = 32,
    parameter int                         IDX_W = 5,
    parameter logic [LEN-1:0][ROM_W-1:0]  INIT  = '1
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] addr,
    output logic [ROM_W-1:0] rdata
);
    logic [ROM_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        rdata_q <= INIT[addr];
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/melody_sequencer.sv
// Steps through the melody ROM, drives buzzer_ctrl's note index and keeps a
// mirror of its on/off switch so every state change is one toggle pulse.
module melody_sequencer
    import buzzer_pkg::*;
#(
    parameter int                        TICK_DIV = 3_125_000,
    parameter int                        GAP_CLKS = 250_000,
    parameter int                        LEN      = 32,
    parameter bit                        LOOP     = 1'b0,
    parameter logic [LEN-1:0][ROM_W-1:0] ROM_INIT = '1
) (
    input  logic          FPGA_CLK,
    input  logic          rst_n,
    melody_sequencer_if.master bus
);
    localparam int IDX_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam int TW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GW    = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;

    seq_state_e       state_q, state_d;
    logic [IDX_W-1:0] addr_q, addr_d;
    logic [TW-1:0]    tick_q, tick_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic [DUR_W-1:0] dur_cnt_q, dur_cnt_d, dur_q, dur_d;
    logic             rest_q, rest_d;
    note_t            data_q, data_d;
    logic             snd_q, snd_d, sound_on_q, sound_on_d, busy_q, busy_d;
    logic [ROM_W-1:0] rom_word;
    logic             tick, want;

    // Addressed by addr_d so the word is already registered when FETCH runs.
    melody_rom #(.LEN(LEN), .IDX_W(IDX_W), .INIT(ROM_INIT)) u_rom (
        .clk(FPGA_CLK), .addr(addr_d), .rdata(rom_word)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        tick_d    = tick_q;
        gap_d     = gap_q;
        dur_cnt_d = dur_cnt_q;
        dur_d     = dur_q;
        rest_d    = rest_q;
        data_d    = data_q;
        tick      = (tick_q == TW'(TICK_DIV - 1));
        if (bus.stop) begin
            state_d = ST_IDLE;
        end else if (bus.start) begin
            state_d = ST_FETCH;
            addr_d  = '0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (is_end(rom_word)) begin
                        if (LOOP) addr_d = '0;
                        else      state_d = ST_IDLE;
                    end else begin
                        data_d    = rom_word[PITCH_LSB +: PITCH_W];
                        rest_d    = rom_word[REST_BIT];
                        dur_d     = rom_word[DUR_LSB +: DUR_W];
                        tick_d    = '0;
                        dur_cnt_d = '0;
                        state_d   = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    tick_d = tick ? '0 : tick_q + 1'b1;
                    if (tick) begin
                        dur_cnt_d = dur_cnt_q + 1'b1;
                        if (dur_cnt_q == dur_q) begin
                            // The last address acts as an implicit END marker.
                            if (addr_q == IDX_W'(LEN - 1)) begin
                                if (LOOP) begin
                                    addr_d  = '0;
                                    state_d = ST_FETCH;
                                end else begin
                                    state_d = ST_IDLE;
                                end
                            end else if (GAP_CLKS == 0) begin
                                addr_d  = addr_q + 1'b1;
                                state_d = ST_FETCH;
                            end else begin
                                gap_d   = '0;
                                state_d = ST_GAP;
                            end
                        end
                    end
                end
                ST_GAP: begin
                    gap_d = gap_q + 1'b1;
                    if (gap_q == GW'(GAP_CLKS - 1)) begin
                        addr_d  = addr_q + 1'b1;
                        state_d = ST_FETCH;
                    end
                end
                default: ;
            endcase
        end

        // FETCH keeps the current switch state so restarts and legato don't blip.
        case (state_d)
            ST_PLAY:  want = ~rest_d;
            ST_FETCH: want = snd_q;
            default:  want = 1'b0;
        endcase
        sound_on_d = (want != snd_q) && !sound_on_q;
        snd_d      = snd_q ^ sound_on_d;
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge FPGA_CLK) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            tick_q     <= '0;
            gap_q      <= '0;
            dur_cnt_q  <= '0;
            dur_q      <= '0;
            rest_q     <= 1'b0;
            data_q     <= '0;
            snd_q      <= 1'b0;
            sound_on_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            tick_q     <= tick_d;
            gap_q      <= gap_d;
            dur_cnt_q  <= dur_cnt_d;
            dur_q      <= dur_d;
            rest_q     <= rest_d;
            data_q     <= data_d;
            snd_q      <= snd_d;
            sound_on_q <= sound_on_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.data     = data_q;
    assign bus.sound_on = sound_on_q;
    assign bus.busy     = busy_q;
    assign bus.note_idx = addr_q;
endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer: three instances (plain melody, melody
// with a rest, looping full ROM) each feeding a toggle-switch buzzer model.
module tb_melody_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    localparam logic [31:0][7:0] ROM_A = {{30{8'hFF}}, 8'h12, 8'h28};
    localparam logic [31:0][7:0] ROM_B = {{29{8'hFF}}, 8'h12, 8'h83, 8'h28};
    localparam logic [7:0][7:0]  ROM_C = {8'h40, 8'h38, 8'h30, 8'h28, 8'h20, 8'h18, 8'h10, 8'h08};

    melody_sequencer_if #(.IDX_W(5)) if_a ();
    melody_sequencer_if #(.IDX_W(5)) if_b ();
    melody_sequencer_if #(.IDX_W(3)) if_c ();

    melody_sequencer #(.TICK_DIV(4), .GAP_CLKS(2), .LEN(32), .LOOP(1'b0), .ROM_INIT(ROM_A)) u_a (
        .FPGA_CLK(clk), .rst_n(rst_n), .bus(if_a.master));
    melody_sequencer #(.TICK_DIV(4), .GAP_CLKS(2), .LEN(32), .LOOP(1'b0), .ROM_INIT(ROM_B)) u_b (
        .FPGA_CLK(clk), .rst_n(rst_n), .bus(if_b.master));
    melody_sequencer #(.TICK_DIV(4), .GAP_CLKS(2), .LEN(8), .LOOP(1'b1), .ROM_INIT(ROM_C)) u_c (
        .FPGA_CLK(clk), .rst_n(rst_n), .bus(if_c.master));

    // buzzer_ctrl switch: flips on every sound_on pulse, cleared with the sequencer
    logic sw_a, sw_b, sw_c;
    always @(posedge clk) begin
        if (!rst_n) begin
            sw_a <= 1'b0; sw_b <= 1'b0; sw_c <= 1'b0;
        end else begin
            if (if_a.sound_on) sw_a <= ~sw_a;
            if (if_b.sound_on) sw_b <= ~sw_b;
            if (if_c.sound_on) sw_c <= ~sw_c;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [33:0] got;
        rst_n = 1'b0;
        repeat (3) step();
        got = {if_a.data, if_a.sound_on, if_a.busy, if_a.note_idx, sw_a,
               if_b.data, if_b.sound_on, if_b.busy, if_b.note_idx, sw_b,
               if_c.data, if_c.sound_on, if_c.busy, if_c.note_idx, sw_c};
        vectors++;
        if (got !== 34'h0) begin
            errors++;
            $display("FAIL reset_values got=%h exp=0", got);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            got = {if_a.data, if_a.sound_on, if_a.busy, if_a.note_idx, sw_a,
                   if_b.data, if_b.sound_on, if_b.busy, if_b.note_idx, sw_b,
                   if_c.data, if_c.sound_on, if_c.busy, if_c.note_idx, sw_c};
            vectors++;
            if (got !== 34'h0) begin
                errors++;
                $display("FAIL idle_after_reset cycle=%0d got=%h exp=0", i, got);
            end
        end
    endtask

    // e counts edges after the one that samples start: FETCH at e=0, first PLAY at e=1.
    task automatic test_two_notes();
        logic [11:0] got, exp;
        logic [3:0]  d;
        logic [4:0]  ix;
        int          n = 0;
        if_a.start = 1'b1; step(); if_a.start = 1'b0;
        for (int e = 0; e < 28; e++) begin
            if (e > 0) step();
            d  = (e == 0) ? 4'd0 : (e <= 7) ? 4'd5 : 4'd2;
            ix = (e <= 6) ? 5'd0 : (e <= 21) ? 5'd1 : 5'd2;
            exp = {d, (e == 1 || e == 5 || e == 8 || e == 20), (e <= 22), ix,
                   ((e >= 2 && e <= 5) || (e >= 9 && e <= 20))};
            got = {if_a.data, if_a.sound_on, if_a.busy, if_a.note_idx, sw_a};
            vectors++;
            if (got !== exp) begin
                errors++;
                $display("FAIL two_notes e=%0d got=%h exp=%h", e, got, exp);
            end
            if (if_a.sound_on) n++;
        end
        vectors++;
        if (n != 4 || sw_a !== 1'b0) begin
            errors++;
            $display("FAIL two_notes_pulses pulses=%0d sw=%b exp 4 pulses sw=0", n, sw_a);
        end
    endtask

    // Rest entry 0x83 is 16 clocks of PLAY with no unmute; between the mute
    // pulse of note 0 and the unmute of note 2 lie 2 gap + 1 fetch + 16 rest
    // + 2 gap + 1 fetch clocks.
    task automatic test_rest();
        logic [11:0] got, exp;
        logic [3:0]  d;
        logic [4:0]  ix;
        int          n = 0;
        int          first_on = -1, last_mute = -1;
        if_b.start = 1'b1; step(); if_b.start = 1'b0;
        for (int e = 0; e < 46; e++) begin
            if (e > 0) step();
            d  = (e == 0) ? 4'd0 : (e <= 7) ? 4'd5 : (e <= 26) ? 4'd0 : 4'd2;
            ix = (e <= 6) ? 5'd0 : (e <= 25) ? 5'd1 : (e <= 40) ? 5'd2 : 5'd3;
            exp = {d, (e == 1 || e == 5 || e == 27 || e == 39), (e <= 41), ix,
                   ((e >= 2 && e <= 5) || (e >= 28 && e <= 39))};
            got = {if_b.data, if_b.sound_on, if_b.busy, if_b.note_idx, sw_b};
            vectors++;
            if (got !== exp) begin
                errors++;
                $display("FAIL rest e=%0d got=%h exp=%h", e, got, exp);
            end
            if (if_b.sound_on) begin
                n++;
                if (n == 2) last_mute = e;
                if (n == 3) first_on = e;
            end
        end
        vectors++;
        if (first_on - last_mute != 22 || n != 4) begin
            errors++;
            $display("FAIL rest_silence gap=%0d pulses=%0d exp gap=22 pulses=4",
                     first_on - last_mute, n);
        end
    endtask

    task automatic test_stop();
        int n = 0;
        if_a.start = 1'b1; step(); if_a.start = 1'b0;
        repeat (3) step();
        vectors++;
        if (sw_a !== 1'b1 || if_a.busy !== 1'b1) begin
            errors++;
            $display("FAIL stop_pre sw=%b busy=%b exp sw=1 busy=1", sw_a, if_a.busy);
        end
        if_a.stop = 1'b1; step(); if_a.stop = 1'b0;
        vectors++;
        if ({if_a.sound_on, if_a.busy} !== 2'b10) begin
            errors++;
            $display("FAIL stop_pulse sound_on=%b busy=%b exp sound_on=1 busy=0",
                     if_a.sound_on, if_a.busy);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            if (if_a.sound_on) n++;
        end
        vectors++;
        if (n != 0 || sw_a !== 1'b0 || if_a.busy !== 1'b0 || if_a.data !== 4'd5) begin
            errors++;
            $display("FAIL stop_after extra=%0d sw=%b busy=%b data=%0d exp 0/0/0/5",
                     n, sw_a, if_a.busy, if_a.data);
        end
        if_a.start = 1'b1; if_a.stop = 1'b1; step();
        if_a.start = 1'b0; if_a.stop = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (if_a.sound_on || if_a.busy) n++;
            step();
        end
        vectors++;
        if (n != 0 || sw_a !== 1'b0) begin
            errors++;
            $display("FAIL start_stop_same busy_or_pulse_cycles=%0d sw=%b exp 0 and sw=0", n, sw_a);
        end
    endtask

    task automatic test_restart();
        int n = 0;
        if_a.start = 1'b1; step(); if_a.start = 1'b0;
        repeat (10) step();
        vectors++;
        if ({if_a.data, if_a.note_idx, sw_a} !== {4'd2, 5'd1, 1'b1}) begin
            errors++;
            $display("FAIL restart_pre data=%0d idx=%0d sw=%b exp 2/1/1", if_a.data, if_a.note_idx, sw_a);
        end
        if_a.start = 1'b1; step(); if_a.start = 1'b0;
        vectors++;
        if ({if_a.note_idx, if_a.busy, if_a.data, if_a.sound_on} !== {5'd0, 1'b1, 4'd2, 1'b0}) begin
            errors++;
            $display("FAIL restart_fetch idx=%0d busy=%b data=%0d sound_on=%b exp 0/1/2/0",
                     if_a.note_idx, if_a.busy, if_a.data, if_a.sound_on);
        end
        step();
        vectors++;
        if ({if_a.data, if_a.sound_on, sw_a} !== {4'd5, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL restart_play data=%0d sound_on=%b sw=%b exp 5/0/1", if_a.data, if_a.sound_on, sw_a);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            if (if_a.sound_on || !sw_a) n++;
        end
        vectors++;
        if (n != 0) begin
            errors++;
            $display("FAIL restart_hold bad_cycles=%0d exp 0", n);
        end
        step();
        vectors++;
        if (if_a.sound_on !== 1'b1) begin
            errors++;
            $display("FAIL restart_gap_mute sound_on=%b exp 1", if_a.sound_on);
        end
        if_a.stop = 1'b1; step(); if_a.stop = 1'b0;
        step();
        vectors++;
        if ({if_a.busy, if_a.sound_on, sw_a} !== 3'b000) begin
            errors++;
            $display("FAIL restart_cleanup busy=%b sound_on=%b sw=%b exp 000", if_a.busy, if_a.sound_on, sw_a);
        end
    endtask

    // Each note is FETCH + 4 PLAY + 2 GAP; the last address goes straight back to FETCH 0.
    task automatic test_loop();
        logic [7:0] got, exp;
        int         nb = 0;
        if_c.start = 1'b1; step(); if_c.start = 1'b0;
        for (int e = 0; e <= 60; e++) begin
            if (e > 0) step();
            if (if_c.busy !== 1'b1) nb++;
            got = {if_c.note_idx, if_c.data, if_c.sound_on};
            exp = 8'h00;
            case (e)
                49: exp = {3'd7, 4'd7, 1'b0};
                50: exp = {3'd7, 4'd8, 1'b1};
                53: exp = {3'd7, 4'd8, 1'b0};
                54: exp = {3'd0, 4'd8, 1'b0};
                55: exp = {3'd0, 4'd1, 1'b0};
                default: exp = got;
            endcase
            if (e == 49 || e == 50 || e == 53 || e == 54 || e == 55) begin
                vectors++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL loop_wrap e=%0d got=%h exp=%h", e, got, exp);
                end
            end
        end
        vectors++;
        if (nb != 0) begin
            errors++;
            $display("FAIL loop_busy low_cycles=%0d exp 0", nb);
        end
        if_c.stop = 1'b1; step(); if_c.stop = 1'b0;
        step();
        vectors++;
        if ({if_c.busy, sw_c} !== 2'b00) begin
            errors++;
            $display("FAIL loop_stop busy=%b sw=%b exp 00", if_c.busy, sw_c);
        end
    endtask

    initial begin
        if_a.start = 1'b0; if_a.stop = 1'b0;
        if_b.start = 1'b0; if_b.stop = 1'b0;
        if_c.start = 1'b0; if_c.stop = 1'b0;
        test_reset();
        test_two_notes();
        test_rest();
        test_stop();
        test_restart();
        test_loop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
